// File: rtl/xform_share_ctrl_if.sv
// rtl/xform_share_ctrl_if.sv - requester/response bus shared by xform_share_ctrl and its clients
interface xform_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_a;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_z;

    modport master (
        output req_valid, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z
    );

    modport slave (
        input  req_valid, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z
    );
endinterface

// File: rtl/xform_share_ctrl.sv
// rtl/xform_share_ctrl.sv - round-robin sharer of the 3-to-2 select transform; XFORM_SHARE_CHECK_EN adds a z self-check
module xform_share_ctrl #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    xform_share_ctrl_if.slave   bus,
    output logic [2:0]          dp_a,
    output logic                dp_sel,
    input  logic [1:0]          dp_out,
    output logic                busy,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, PASS0, PASS1, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [2:0]     op;
    logic [1:0]     hi;
    logic [1:0]     lo;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;

    // Round-robin search starting just above the last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = PASS0;
            PASS0:   state_nxt = PASS1;
            PASS1:   state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && gnt_found) begin
            bus.req_ready = NREQ'(1) << gnt_idx;
        end
        bus.rsp_valid = (state == RESP);
        bus.rsp_z     = (state == RESP) ? {~hi, lo} : 4'b0000;
        bus.rsp_id    = (state == RESP) ? id : '0;
        dp_a          = op;
        dp_sel        = (state == PASS1);
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDW'(NREQ - 1);
            id  <= '0;
            op  <= 3'b000;
            hi  <= 2'b00;
            lo  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        op  <= bus.req_a[3*gnt_idx +: 3];
                        id  <= gnt_idx;
                        ptr <= gnt_idx;
                    end
                end
                PASS0:   hi <= dp_out;
                PASS1:   lo <= dp_out;
                default: ;
            endcase
        end
    end

`ifdef XFORM_SHARE_CHECK_EN
    logic [3:0] model_z;

    always_comb begin
        model_z = {~((op[2] & op[1]) | (op[2] & op[0])),
                   ~(op[2] ^ (op[0] | op[1])),
                   ~(op[0] ^ op[1]),
                   ~op[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == RESP && model_z != bus.rsp_z) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_xform_share_ctrl.sv
// tb/tb_xform_share_ctrl.sv - directed self-checking bench for xform_share_ctrl
module tb_xform_share_ctrl;
    logic       clk;
    logic       rst_n;
    logic [2:0] dp_a;
    logic       dp_sel;
    logic [1:0] dp_out;
    logic       busy;
    logic       err;
    logic       stuck;
    int         n_checks;
    int         n_pass;

    xform_share_ctrl_if #(.NREQ(4), .IDW(2)) bus ();

    xform_share_ctrl #(.NREQ(4), .IDW(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .dp_a   (dp_a),
        .dp_sel (dp_sel),
        .dp_out (dp_out),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] zf(input logic [2:0] a);
        return {~((a[2] & a[1]) | (a[2] & a[0])),
                ~(a[2] ^ (a[0] | a[1])),
                ~(a[0] ^ a[1]),
                ~a[0]};
    endfunction

    // Reference datapath, optionally with out[0] stuck high
    always_comb begin
        dp_out = dp_sel ? zf(dp_a)[1:0] : ~zf(dp_a)[3:2];
        if (stuck) dp_out[0] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_one(input int idx, input logic [2:0] a, input logic [3:0] exp_z);
        bus.req_a[3*idx +: 3] = a;
        bus.req_valid         = 4'b0000;
        bus.req_valid[idx]    = 1'b1;
        bus.rsp_ready         = 1'b1;
        #1;
        check("grant", 32'(bus.req_ready), 32'(4'b0001 << idx));
        tick();
        bus.req_valid = 4'b0000;
        check("pass0_sel", 32'(dp_sel), 32'd0);
        check("pass0_out", 32'(dp_out), 32'({~exp_z[3], ~exp_z[2]}));
        tick();
        check("pass1_sel", 32'(dp_sel), 32'd1);
        check("pass1_out", 32'(dp_out), 32'(exp_z[1:0]));
        tick();
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_z", 32'(bus.rsp_z), 32'(exp_z));
        check("rsp_id", 32'(bus.rsp_id), 32'(idx));
        tick();
    endtask

    initial begin
        logic [3:0] exp_rr [4];
        exp_rr = '{4'b1111, 4'b0110, 4'b0100, 4'b1010};
        n_checks      = 0;
        n_pass        = 0;
        stuck         = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_a     = 12'h000;
        bus.rsp_ready = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_z", 32'(bus.rsp_z), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_dp_a", 32'(dp_a), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        do_reset();

        // requester 0 alone, a=101
        run_one(0, 3'b101, 4'b0100);

        // all four continuously valid: grants 0,1,2,3,0
        do_reset();
        bus.req_a     = {3'b011, 3'b101, 3'b111, 3'b000};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 5; t++) begin
            check("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (t % 4)));
            if (t == 4) bus.req_valid = 4'b0000;
            tick();
            tick();
            tick();
            if (t < 4) begin
                check("rr_z", 32'(bus.rsp_z), 32'(exp_rr[t]));
                check("rr_id", 32'(bus.rsp_id), 32'(t));
            end
            tick();
        end

        // back-pressure held in RESP
        bus.req_a[5:3] = 3'b111;
        bus.req_valid  = 4'b0010;
        bus.rsp_ready  = 1'b0;
        #1;
        check("bp_grant", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        bus.req_a[11:9] = 3'b101;
        bus.req_valid   = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_z", 32'(bus.rsp_z), 32'b0110);
            check("bp_id", 32'(bus.rsp_id), 32'd1);
            check("bp_no_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_next_grant", 32'(bus.req_ready), 32'b1000);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check("bp_next_z", 32'(bus.rsp_z), 32'b0100);
        check("bp_next_id", 32'(bus.rsp_id), 32'd3);
        tick();

        // reset pulse during PASS1
        run_one(1, 3'b010, zf(3'b010));
        bus.req_a[11:9] = 3'b111;
        bus.req_a[2:0]  = 3'b000;
        bus.req_valid   = 4'b1001;
        #1;
        check("ar_grant", 32'(bus.req_ready), 32'b1000);
        tick();
        tick();
        check("ar_in_pass1", 32'(dp_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("ar_dp_sel", 32'(dp_sel), 32'd0);
        check("ar_dp_a", 32'(dp_a), 32'd0);
        check("ar_req_ready", 32'(bus.req_ready), 32'd0);
        check("ar_rsp_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_lowest_grant", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check("ar_z", 32'(bus.rsp_z), 32'b1111);
        check("ar_id", 32'(bus.rsp_id), 32'd0);
        tick();

        // operand sweep from requester 2
        for (int a = 0; a < 8; a++) begin
            run_one(2, 3'(a), zf(3'(a)));
        end

`ifdef XFORM_SHARE_CHECK_EN
        stuck         = 1'b1;
        bus.req_a[2:0] = 3'b111;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        #1;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        check("stuck_z", 32'(bus.rsp_z), 32'b0011);
        bus.rsp_ready = 1'b1;
        tick();
        check("stuck_err", 32'(err), 32'd1);
        stuck = 1'b0;
        tick();
        check("stuck_err_sticky", 32'(err), 32'd1);
`else
        check("err_tied", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
